// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// alarm_pkg : shared widths and FSM encoding for the alarm sequencer
// Rev 1.0
// ============================================================================
package alarm_pkg;

  localparam int CNT_W  = 12;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SCNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  function automatic logic time_match(
    input logic [HOUR_W-1:0] cur_h,
    input logic [MIN_W-1:0]  cur_m,
    input logic [HOUR_W-1:0] alm_h,
    input logic [MIN_W-1:0]  alm_m
  );
    return (cur_h == alm_h) && (cur_m == alm_m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_countdown.sv
`default_nettype none
// ============================================================================
// alarm_countdown : loadable seconds down-counter, saturates at zero
// Rev 1.0
// ============================================================================
module alarm_countdown
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  assign cnt    = r_cnt;
  assign expire = tick && (r_cnt == CNT_W'(1));

  // load beats tick so a reload on the expiring second starts a fresh interval
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
// alarm_scheduler : alarm match detect, ring timeout, snooze and dismiss FSM
// Rev 1.0
// ============================================================================
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1s,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] alm_hour,
  input  logic [MIN_W-1:0]  alm_min,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              dismiss,
  output logic              alarm_start,
  output logic              snoozing,
  output logic [SCNT_W-1:0] snooze_count,
  output logic              missed
);

  localparam logic [CNT_W-1:0]  c_RING_LOAD   = CNT_W'(RING_SECONDS);
  localparam logic [CNT_W-1:0]  c_SNOOZE_LOAD = CNT_W'(SNOOZE_MINUTES * 60);
  localparam logic [SCNT_W-1:0] c_MAX_SNZ     = SCNT_W'(MAX_SNOOZES);

  state_t            r_state;
  logic              r_match_q;
  logic [SCNT_W-1:0] r_scnt;
  logic              r_missed;
  logic              r_alarm_start;
  logic              r_snoozing;

  state_t            w_state_nxt;
  logic [SCNT_W-1:0] w_scnt_nxt;
  logic              w_missed_nxt;
  logic              w_match;
  logic              w_trigger;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_cnt_tick;
  logic              w_expire;
  logic [CNT_W-1:0]  w_cnt;

  assign w_match   = time_match(cur_hour, cur_min, alm_hour, alm_min);
  assign w_trigger = w_match & ~r_match_q & alarm_en;

  // Any button pulse seen while active swallows that second's tick
  assign w_cnt_tick = tick_1s & alarm_en & ~dismiss &
                      (((r_state == ST_RINGING) & ~snooze) | (r_state == ST_SNOOZE));

  alarm_countdown u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (w_cnt_tick),
    .cnt      (w_cnt),
    .expire   (w_expire)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_scnt_nxt   = r_scnt;
    w_missed_nxt = r_missed;
    w_load       = 1'b0;
    w_load_val   = c_RING_LOAD;

    if (!alarm_en) begin
      w_state_nxt = ST_IDLE;
      w_scnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            w_state_nxt  = ST_RINGING;
            w_load       = 1'b1;
            w_scnt_nxt   = '0;
            w_missed_nxt = 1'b0;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            w_state_nxt  = ST_IDLE;
            w_scnt_nxt   = '0;
            w_missed_nxt = 1'b0;
          end else if (snooze) begin
            if (r_scnt < c_MAX_SNZ) begin
              w_state_nxt = ST_SNOOZE;
              w_load      = 1'b1;
              w_load_val  = c_SNOOZE_LOAD;
              w_scnt_nxt  = r_scnt + SCNT_W'(1);
            end
          end else if (w_expire) begin
            w_state_nxt  = ST_IDLE;
            w_missed_nxt = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            w_state_nxt  = ST_IDLE;
            w_scnt_nxt   = '0;
            w_missed_nxt = 1'b0;
          end else if (w_expire) begin
            w_state_nxt = ST_RINGING;
            w_load      = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Match history resets high so a reset inside the alarm minute does not ring
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_match_q     <= 1'b1;
      r_scnt        <= '0;
      r_missed      <= 1'b0;
      r_alarm_start <= 1'b0;
      r_snoozing    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_match_q     <= w_match;
      r_scnt        <= w_scnt_nxt;
      r_missed      <= w_missed_nxt;
      r_alarm_start <= (w_state_nxt == ST_RINGING);
      r_snoozing    <= (w_state_nxt == ST_SNOOZE);
    end
  end

  assign alarm_start  = r_alarm_start;
  assign snoozing     = r_snoozing;
  assign snooze_count = r_scnt;
  assign missed       = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// tb_alarm_scheduler : directed vector bench for alarm_scheduler
// Rev 1.0
// ============================================================================
module tb_alarm_scheduler;

  logic       clk;
  logic       rst;
  logic       tick_1s;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic       alarm_en;
  logic       snooze;
  logic       dismiss;
  logic       alarm_start;
  logic       snoozing;
  logic [2:0] snooze_count;
  logic       missed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] am;
    logic [5:0] cm;
    logic       en;
    logic       snz;
    logic       dis;
    int         ticks;
    logic [5:0] exp_out;  // {alarm_start, snoozing, snooze_count, missed}
    string      name;
  } vec_t;

  vec_t vecs[$];

  alarm_scheduler #(
    .RING_SECONDS   (3),
    .SNOOZE_MINUTES (1),
    .MAX_SNOOZES    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1s      (tick_1s),
    .cur_hour     (cur_hour),
    .cur_min      (cur_min),
    .alm_hour     (alm_hour),
    .alm_min      (alm_min),
    .alarm_en     (alarm_en),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .alarm_start  (alarm_start),
    .snoozing     (snoozing),
    .snooze_count (snooze_count),
    .missed       (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] am, input logic [5:0] cm, input logic en,
                              input logic snz, input logic dis, input int ticks,
                              input logic st, input logic sz, input logic [2:0] sc,
                              input logic ms, input string name);
    vec_t v;
    v.am = am; v.cm = cm; v.en = en; v.snz = snz; v.dis = dis; v.ticks = ticks;
    v.exp_out = {st, sz, sc, ms};
    v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [5:0] exp_out);
    logic [5:0] got;
    got = {alarm_start, snoozing, snooze_count, missed};
    checks++;
    if (got !== exp_out) begin
      errors++;
      $display("FAIL %s: got {start,snz,cnt,missed}=%b_%b_%0d_%b expected %b_%b_%0d_%b",
               name, got[5], got[4], got[3:1], got[0],
               exp_out[5], exp_out[4], exp_out[3:1], exp_out[0]);
    end
  endtask

  // Buttons last one clock; each tick is followed by three idle clocks
  task automatic run_row(input vec_t v);
    @(negedge clk);
    alm_min  = v.am;
    cur_min  = v.cm;
    alarm_en = v.en;
    snooze   = v.snz;
    dismiss  = v.dis;
    @(negedge clk);
    snooze  = 1'b0;
    dismiss = 1'b0;
    for (int i = 0; i < v.ticks; i++) begin
      tick_1s = 1'b1;
      @(negedge clk);
      tick_1s = 1'b0;
      repeat (3) @(negedge clk);
    end
    check(v.name, v.exp_out);
  endtask

  initial begin
    rst      = 1'b0;
    tick_1s  = 1'b0;
    cur_hour = 5'd7;
    cur_min  = 6'd29;
    alm_hour = 5'd7;
    alm_min  = 6'd30;
    alarm_en = 1'b0;
    snooze   = 1'b0;
    dismiss  = 1'b0;

    //             alm cur en snz dis tk  st sz cnt ms
    vecs.push_back(mk(30, 29, 1, 0, 0, 0,  0, 0, 0, 0, "pre_match"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 0,  1, 0, 0, 0, "ring_rise"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 2,  1, 0, 0, 0, "ring_2ticks"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 1,  0, 0, 0, 1, "timeout"));
    vecs.push_back(mk(30, 31, 1, 0, 0, 0,  0, 0, 0, 1, "no_match"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 0,  1, 0, 0, 0, "retrig_clr_missed"));
    vecs.push_back(mk(30, 30, 1, 1, 0, 0,  0, 1, 1, 0, "snooze1"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 59, 0, 1, 1, 0, "snooze_59s"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 1,  1, 0, 1, 0, "snooze_expire"));
    vecs.push_back(mk(30, 30, 1, 1, 0, 0,  0, 1, 2, 0, "snooze2"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 60, 1, 0, 2, 0, "ring_again"));
    vecs.push_back(mk(30, 30, 1, 1, 0, 0,  1, 0, 2, 0, "snooze3_ignored"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 2,  1, 0, 2, 0, "ring_after_ignore"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 1,  0, 0, 2, 1, "timeout_max"));
    vecs.push_back(mk(30, 31, 1, 0, 0, 0,  0, 0, 2, 1, "leave_minute"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 0,  1, 0, 0, 0, "ring_3"));
    vecs.push_back(mk(30, 30, 1, 1, 1, 0,  0, 0, 0, 0, "snz_dis_same"));
    vecs.push_back(mk(30, 31, 1, 0, 0, 0,  0, 0, 0, 0, "leave_minute2"));
    vecs.push_back(mk(30, 30, 1, 0, 0, 0,  1, 0, 0, 0, "ring_4"));
    vecs.push_back(mk(30, 30, 1, 1, 0, 0,  0, 1, 1, 0, "snooze_4"));
    vecs.push_back(mk(30, 30, 1, 0, 1, 0,  0, 0, 0, 0, "dismiss_snooze"));

    repeat (3) @(negedge clk);
    check("reset_state", 6'b0);
    rst = 1'b1;

    foreach (vecs[i]) run_row(vecs[i]);

    // Asynchronous reset mid-ring, released inside the alarm minute
    @(negedge clk); cur_min = 6'd31;
    @(negedge clk); cur_min = 6'd30;
    @(negedge clk);
    check("A_ring", 6'b100000);
    rst = 1'b0;
    #1;
    check("A_async_reset", 6'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("A_no_rering", 6'b0);
    alm_min = 6'd31;
    @(negedge clk);
    alm_min = 6'd30;
    @(negedge clk);
    check("A_alm_edit", 6'b100000);

    // Disarm during snooze, re-arm within the same minute
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    check("B_snooze", 6'b010010);
    alarm_en = 1'b0;
    @(negedge clk);
    check("B_en_drop", 6'b0);
    alarm_en = 1'b1;
    repeat (3) @(negedge clk);
    check("B_no_ring", 6'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Sequencer for the alarm LED pattern generator (led_alarm) in the digital clock. It compares the running time against the user alarm setting and drives the generator's level-sensitive start input. It also manages ring timeout, snooze (bounded count) and dismiss. It sits between the timekeeping core / button debouncers and led_alarm.

Parameters:
RING_SECONDS, 60, seconds alarm_start stays high before auto-timeout (1..255)
SNOOZE_MINUTES, 5, snooze interval in minutes; loaded as SNOOZE_MINUTES*60 ticks (1..60)
MAX_SNOOZES, 3, snoozes allowed per alarm event (1..7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick_1s  in  1  one-cycle pulse per second from timekeeping core
cur_hour  in  5  current hour, binary 0-23
cur_min  in  6  current minute, binary 0-59
alm_hour  in  5  alarm hour, binary 0-23
alm_min  in  6  alarm minute, binary 0-59
alarm_en  in  1  alarm armed (level)
snooze  in  1  debounced one-cycle button pulse
dismiss  in  1  debounced one-cycle button pulse
alarm_start  out  1  level to led_alarm start; high only in RINGING
snoozing  out  1  high in SNOOZE
snooze_count  out  3  snoozes used in current event
missed  out  1  sticky: last ring timed out unanswered

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counters 0, match_q=1 (no ring if reset lands inside the alarm minute).
- match = (cur_hour==alm_hour)&&(cur_min==alm_min); match_q registers match every cycle. Trigger = match & ~match_q & alarm_en.
- States (alarm_pkg::state_t): IDLE, RINGING, SNOOZE. All outputs registered and decoded from the state register.
- IDLE: trigger -> RINGING; load countdown=RING_SECONDS; snooze_count=0; missed=0.
- RINGING: priority dismiss > snooze > timeout.
  dismiss -> IDLE, snooze_count=0.
  snooze with snooze_count<MAX_SNOOZES -> SNOOZE; countdown=SNOOZE_MINUTES*60; snooze_count+1.
  snooze with snooze_count==MAX_SNOOZES -> ignored, keep ringing, countdown unchanged.
  tick_1s decrements countdown; tick with countdown==1 -> IDLE, missed=1.
- SNOOZE: dismiss -> IDLE, snooze_count=0. tick_1s decrements; tick with countdown==1 -> RINGING, countdown=RING_SECONDS.
- alarm_en=0 in any state -> IDLE next cycle; missed unchanged; snooze_count=0.
- Same-cycle button and tick: the button is acted on and the tick is dropped.
- Same-cycle snooze and dismiss: dismiss wins.
- Trigger while RINGING/SNOOZE (alarm time edited to the current minute): ignored.
- Latency: time inputs first match after edge N -> alarm_start=1 after edge N+1. Button pulse in cycle K -> alarm_start=0 after edge K+1.
- Countdown width 12 bits (max 3600); never underflows. Load values are computed at elaboration.
- missed clears on the next trigger or on dismiss.

Decomposition:
- alarm_pkg: state_t enum; CNT_W=12; HOUR_W=5; MIN_W=6; SCNT_W=3.
- Sub-module alarm_countdown holds the loadable down-counter.
  Ports: clk, rst, load, load_val, tick, cnt, expire.
  expire = tick && cnt==1.
- FSM and comparator stay in alarm_scheduler.

Test Plan:
Bench params: RING_SECONDS=3, SNOOZE_MINUTES=1, MAX_SNOOZES=2; tick every 4 clk.
- alm=07:30, en=1, cur steps 07:29->07:30 -> alarm_start rises one clk later; after 3 ticks falls; missed=1; state IDLE.
- Ringing, pulse snooze -> alarm_start=0, snoozing=1, snooze_count=1; after 60 ticks alarm_start=1 again.
- Snooze twice (count=2), third snooze while ringing -> ignored, alarm_start stays 1, snooze_count=2.
- Ringing, snooze and dismiss in the same cycle -> IDLE, snooze_count=0, snoozing=0, missed=0.
- Assert rst=0 mid-RINGING at 07:30, release while still 07:30 -> no re-ring; 07:31->07:30 via alarm edit re-triggers.
- SNOOZE, drop alarm_en -> IDLE next clk; raise en inside the same minute -> no ring (no match rise).
